uart_rx_input: RTL and testbench

Serial receive front-end for the CPU's UART input path. Deserialises 8N1 frames from the `rxd` pin and buffers received bytes in a small FIFO. Presents the oldest byte, zero-extended, on `input_data`/`input_ready` to the register-write stage. Pops one byte each time that stage asserts `UART_write_enable`, which is wired to `input_consume`.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 58 +++++
 rtl/uart_rx_input.sv | 141 ++++++++++++++
 tb/tb_uart_rx_input.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with show-ahead output. A push into a full buffer is
// still accepted when a pop happens in the same cycle; otherwise it is dropped.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      empty,
  output logic                      full,
  output logic                      drop
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      do_push;
  logic                      do_pop;

  // Status and handshake qualification; a pop on an empty buffer is ignored.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage write; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_input.sv
// 8N1 UART receiver front-end feeding a byte FIFO read by the register-write
// stage. The head byte is presented zero-extended to 32 bits.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on rxs
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; push on high, frame error on low
module uart_rx_input
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic        input_consume,
  output logic [31:0] input_data,
  output logic        input_ready,
  output logic        overrun,
  output logic        frame_error
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rxd_meta;
  logic                      rxs;
  rx_state_t                 state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [2:0]                bit_idx, idx_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic                      push;
  logic                      ferr_set;
  logic [UART_DATA_BITS-1:0] head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_drop;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  // Next-state, counters, shift register and push/error strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = bit_idx;
    shift_next = shift;
    push       = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxs, shift[UART_DATA_BITS-1:1]};
          idx_next   = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          push       = rxs;
          ferr_set   = !rxs;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= idx_next;
      shift   <= shift_next;
    end
  end

  // Sticky error flags; only reset clears them. A drop can only occur while
  // the buffer is full, so the full qualifier is a consistency guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (fifo_drop && fifo_full) overrun <= 1'b1;
      if (ferr_set)               frame_error <= 1'b1;
    end
  end

  byte_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (shift),
    .pop  (input_consume),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full),
    .drop (fifo_drop)
  );

  // Show-ahead output, forced to zero while empty.
  always_comb begin
    input_ready = !fifo_empty;
    input_data  = input_ready ? {{(32-UART_DATA_BITS){1'b0}}, head} : 32'b0;
  end

endmodule

// File: tb/tb_uart_rx_input.sv
// Scoreboard bench for uart_rx_input at 16 clocks per bit.
module tb_uart_rx_input;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic        input_consume = 1'b0;
  logic [31:0] input_data;
  logic        input_ready;
  logic        overrun;
  logic        frame_error;

  logic [7:0]  sb [$];
  int          n_checks = 0;
  int          n_pass = 0;

  uart_rx_input #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .input_consume(input_consume),
    .input_data   (input_data),
    .input_ready  (input_ready),
    .overrun      (overrun),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    sb.delete();
  endtask

  // Drives one frame with no idle before or after; the expected byte goes
  // into the scoreboard when the frame should land in the FIFO.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_push);
    if (expect_push) sb.push_back(b);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic consume_one(input string tag);
    logic [7:0] exp;
    exp = 8'h00;
    check({tag, "_ready"}, {31'b0, input_ready}, 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    check({tag, "_data"}, input_data, {24'b0, exp});
    input_consume = 1'b1;
    tick(1);
    input_consume = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) consume_one(tag);
    check({tag, "_empty"}, {31'b0, input_ready}, 32'd0);
  endtask

  initial begin
    tick(1);
    do_reset();
    check("rst_data",  input_data, 32'd0);
    check("rst_ready", {31'b0, input_ready}, 32'd0);
    check("rst_ovr",   {31'b0, overrun}, 32'd0);
    check("rst_ferr",  {31'b0, frame_error}, 32'd0);
    tick(3);

    // Single frame: STOP sample lands 155 edges after the start edge.
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        tick(154);
        check("single_pre_ready", {31'b0, input_ready}, 32'd0);
        tick(1);
        check("single_ready", {31'b0, input_ready}, 32'd1);
        check("single_data", input_data, 32'h0000_00A5);
      end
    join
    consume_one("single_pop");
    check("single_after_pop", {31'b0, input_ready}, 32'd0);
    tick(5);

    // Glitch shorter than half a bit.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    check("glitch_ready", {31'b0, input_ready}, 32'd0);
    check("glitch_ferr", {31'b0, frame_error}, 32'd0);

    // Framing error then a valid byte.
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(20);
    check("ferr_set", {31'b0, frame_error}, 32'd1);
    check("ferr_nopush", {31'b0, input_ready}, 32'd0);
    send_frame(8'h11, 1'b1, 1'b1);
    tick(3);
    check("ferr_sticky", {31'b0, frame_error}, 32'd1);
    drain("ferr_next");

    // Ordering and overrun: 17 back-to-back bytes into a 16-deep buffer.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, i < 16);
    tick(3);
    check("ovr_set", {31'b0, overrun}, 32'd1);
    drain("ovr_order");

    // Full buffer with pop on the push cycle.
    do_reset();
    tick(3);
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b1);
    fork
      send_frame(8'h7E, 1'b1, 1'b1);
      begin
        tick(154);
        consume_one("fullpp_pop");
      end
    join
    tick(3);
    check("fullpp_no_ovr", {31'b0, overrun}, 32'd0);
    drain("fullpp_drain");

    // Reset during DATA bit 4 with data and a frame error pending.
    send_frame(8'h33, 1'b1, 1'b1);
    send_frame(8'h44, 1'b0, 1'b0);
    tick(20);
    check("midrst_pre_ferr", {31'b0, frame_error}, 32'd1);
    check("midrst_pre_ready", {31'b0, input_ready}, 32'd1);
    fork
      send_frame(8'hF5, 1'b1, 1'b0);
      begin
        tick(CPB * 5 + 8);
        do_reset();
        check("midrst_data", input_data, 32'd0);
        check("midrst_ready", {31'b0, input_ready}, 32'd0);
        check("midrst_ovr", {31'b0, overrun}, 32'd0);
        check("midrst_ferr", {31'b0, frame_error}, 32'd0);
      end
    join
    tick(30);
    check("midrst_abort", {31'b0, input_ready}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    tick(2);
    drain("midrst_next");

    // Pointer wrap over many send/consume pairs.
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      tick(2);
      consume_one("wrap");
    end
    check("wrap_empty", {31'b0, input_ready}, 32'd0);
    check("wrap_ovr", {31'b0, overrun}, 32'd0);
    check("wrap_ferr", {31'b0, frame_error}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
